// File: rtl/obf_pkg.sv
// Shared cell codes, locked-key constant and FSM state type for the keyed
// camouflage array.
package obf_pkg;

    localparam logic [1:0] OBF_PASS = 2'b00;
    localparam logic [1:0] OBF_INV  = 2'b10;
    localparam logic [1:0] OBF_ONE  = 2'b01;
    localparam logic [1:0] OBF_ZERO = 2'b11;

    // Locked key is all ones: every cell forced to const0.
    localparam logic [1:0] OBF_LOCKED_CELL = OBF_ZERO;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        SHIFT  = 2'd1,
        ACTIVE = 2'd2
    } obf_state_t;

endpackage

// File: rtl/obf_cell.sv
// One camouflage cell: 4-way function select of a single net by its 2-bit key.
module obf_cell
    import obf_pkg::*;
(
    input  logic [1:0] key,
    input  logic       sig_in,
    output logic       sig_out
);

    always_comb begin
        case (key)
            OBF_PASS: sig_out = sig_in;
            OBF_INV:  sig_out = ~sig_in;
            OBF_ONE:  sig_out = 1'b1;
            default:  sig_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/obf_keyed_cell_array.sv
// Key-programmable camouflage stage: serial shadow key load, atomic commit
// into the active key, NUM_CELLS keyed cells and an optional output register.
//
// state  | meaning
// LOCKED | after reset/clear, active key all ones, outputs const0
// SHIFT  | shadow loading, previous active key still in effect
// ACTIVE | committed key in effect, key_ready high
module obf_keyed_cell_array
    import obf_pkg::*;
#(
    parameter  int NUM_CELLS = 8,
    parameter  int OUT_REG   = 0,
    localparam int KEY_W     = 2 * NUM_CELLS,
    localparam int CNT_W     = $clog2(KEY_W + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in,
    input  logic                 key_shift,
    input  logic                 key_commit,
    input  logic                 key_clear,
    input  logic [NUM_CELLS-1:0] sig_in,
    output logic [NUM_CELLS-1:0] sig_out,
    output logic                 key_ready,
    output logic                 key_err,
    output logic [CNT_W-1:0]     load_cnt
);

    localparam logic [KEY_W-1:0] LOCKED_KEY = {NUM_CELLS{OBF_LOCKED_CELL}};
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] CNT_OVER   = CNT_W'(KEY_W + 1);

    obf_state_t           state_q, state_d;
    logic [KEY_W-1:0]     shadow_q;
    logic [KEY_W-1:0]     active_q;
    logic [NUM_CELLS-1:0] cell_out;
    logic                 commit_ok;
    logic                 commit_bad;

    always_comb begin
        state_d    = state_q;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        if (key_clear) begin
            state_d = LOCKED;
        end else begin
            if (key_commit) begin
                // A commit sharing its cycle with a shift is always rejected.
                if (state_q == SHIFT && load_cnt == CNT_FULL && !key_shift) begin
                    commit_ok = 1'b1;
                    state_d   = ACTIVE;
                end else begin
                    commit_bad = 1'b1;
                end
            end
            if (key_shift) begin
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOCKED;
            shadow_q <= '0;
            active_q <= LOCKED_KEY;
            load_cnt <= '0;
            key_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_err <= commit_bad;
            if (key_clear) begin
                shadow_q <= '0;
                active_q <= LOCKED_KEY;
                load_cnt <= '0;
            end else if (key_shift) begin
                shadow_q <= {shadow_q[KEY_W-2:0], key_in};
                if (state_q != SHIFT) begin
                    load_cnt <= CNT_W'(1);
                end else if (load_cnt != CNT_OVER) begin
                    load_cnt <= load_cnt + CNT_W'(1);
                end
            end else if (commit_ok) begin
                active_q <= shadow_q;
                load_cnt <= '0;
            end
        end
    end

    assign key_ready = (state_q == ACTIVE);

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        obf_cell u_cell (
            .key     (active_q[2*i+1 -: 2]),
            .sig_in  (sig_in[i]),
            .sig_out (cell_out[i])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_CELLS-1:0] sig_out_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sig_out_q <= '0;
            end else begin
                sig_out_q <= cell_out;
            end
        end
        assign sig_out = sig_out_q;
    end else begin : g_out_comb
        assign sig_out = cell_out;
    end

endmodule

// File: tb/tb_obf_keyed_cell_array.sv
// Directed bench for obf_keyed_cell_array: one combinational-output and one
// registered-output instance driven by the same stimulus, NUM_CELLS=4.
module tb_obf_keyed_cell_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_in = 1'b0;
    logic       key_shift = 1'b0;
    logic       key_commit = 1'b0;
    logic       key_clear = 1'b0;
    logic [3:0] sig_in = 4'b0000;

    logic [3:0] sig_out, sig_out_r;
    logic       key_ready, key_ready_r;
    logic       key_err, key_err_r;
    logic [3:0] load_cnt, load_cnt_r;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    obf_keyed_cell_array #(.NUM_CELLS(4), .OUT_REG(0)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_shift(key_shift),
        .key_commit(key_commit), .key_clear(key_clear), .sig_in(sig_in),
        .sig_out(sig_out), .key_ready(key_ready), .key_err(key_err),
        .load_cnt(load_cnt)
    );

    obf_keyed_cell_array #(.NUM_CELLS(4), .OUT_REG(1)) dut_r (
        .clk(clk), .rst(rst), .key_in(key_in), .key_shift(key_shift),
        .key_commit(key_commit), .key_clear(key_clear), .sig_in(sig_in),
        .sig_out(sig_out_r), .key_ready(key_ready_r), .key_err(key_err_r),
        .load_cnt(load_cnt_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        key_in    = b;
        key_shift = 1'b1;
        tick();
        key_shift = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] k);
        logic [7:0] kv;
        kv = k;
        for (int i = 7; i >= 0; i--) shift_bit(kv[i]);
    endtask

    task automatic commit();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sig_in = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vecs++; if (sig_out !== 4'b0000) begin $display("FAIL reset_sig_out got %b want 0000", sig_out); errs++; end
        vecs++; if (sig_out_r !== 4'b0000) begin $display("FAIL reset_sig_out_r got %b want 0000", sig_out_r); errs++; end
        vecs++; if (key_ready !== 1'b0) begin $display("FAIL reset_key_ready got %b want 0", key_ready); errs++; end
        vecs++; if (load_cnt !== 4'd0) begin $display("FAIL reset_load_cnt got %0d want 0", load_cnt); errs++; end
        vecs++; if (key_err !== 1'b0) begin $display("FAIL reset_key_err got %b want 0", key_err); errs++; end
    endtask

    task automatic test_normal_load();
        sig_in = 4'b1011;
        shift_byte(8'b1101_1000);
        vecs++; if (load_cnt !== 4'd8) begin $display("FAIL load_cnt_full got %0d want 8", load_cnt); errs++; end
        vecs++; if (sig_out !== 4'b0000) begin $display("FAIL load_locked_out got %b want 0000", sig_out); errs++; end
        commit();
        vecs++; if (sig_out !== 4'b0101) begin $display("FAIL load_sig_out got %b want 0101", sig_out); errs++; end
        vecs++; if (key_ready !== 1'b1) begin $display("FAIL load_key_ready got %b want 1", key_ready); errs++; end
        vecs++; if (load_cnt !== 4'd0) begin $display("FAIL load_cnt_after got %0d want 0", load_cnt); errs++; end
        vecs++; if (key_err !== 1'b0) begin $display("FAIL load_key_err got %b want 0", key_err); errs++; end
        vecs++; if (sig_out_r !== 4'b0000) begin $display("FAIL load_reg_early got %b want 0000", sig_out_r); errs++; end
        vecs++; if (key_ready_r !== 1'b1) begin $display("FAIL load_reg_ready got %b want 1", key_ready_r); errs++; end
        tick();
        vecs++; if (sig_out_r !== 4'b0101) begin $display("FAIL load_reg_sig_out got %b want 0101", sig_out_r); errs++; end
        sig_in = 4'b0100;
        #1;
        vecs++; if (sig_out !== 4'b0110) begin $display("FAIL comb_latency got %b want 0110", sig_out); errs++; end
        vecs++; if (sig_out_r !== 4'b0101) begin $display("FAIL reg_latency_hold got %b want 0101", sig_out_r); errs++; end
        tick();
        vecs++; if (sig_out_r !== 4'b0110) begin $display("FAIL reg_latency got %b want 0110", sig_out_r); errs++; end
        sig_in = 4'b1011;
    endtask

    task automatic test_short_load();
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        vecs++; if (load_cnt !== 4'd7) begin $display("FAIL short_cnt got %0d want 7", load_cnt); errs++; end
        vecs++; if (key_ready !== 1'b0) begin $display("FAIL short_ready got %b want 0", key_ready); errs++; end
        commit();
        vecs++; if (key_err !== 1'b1) begin $display("FAIL short_err got %b want 1", key_err); errs++; end
        vecs++; if (sig_out !== 4'b0101) begin $display("FAIL short_sig_out got %b want 0101", sig_out); errs++; end
        tick();
        vecs++; if (key_err !== 1'b0) begin $display("FAIL short_err_pulse got %b want 0", key_err); errs++; end
        shift_bit(1'b0);
        commit();
        vecs++; if (key_ready !== 1'b1) begin $display("FAIL short_recover_ready got %b want 1", key_ready); errs++; end
        vecs++; if (sig_out !== 4'b1011) begin $display("FAIL short_recover_out got %b want 1011", sig_out); errs++; end
    endtask

    task automatic test_reload_traffic();
        logic [7:0] k;
        logic [3:0] pats [8];
        pats = '{4'h3, 4'h9, 4'hE, 4'h0, 4'h5, 4'hC, 4'h7, 4'hA};
        k = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            sig_in = pats[i];
            #1;
            vecs++; if (sig_out !== pats[i]) begin $display("FAIL reload_pass_%0d got %b want %b", i, sig_out, pats[i]); errs++; end
            if (i == 7) key_commit = 1'b1;
            shift_bit(k[7-i]);
            key_commit = 1'b0;
        end
        vecs++; if (key_err !== 1'b1) begin $display("FAIL reload_shift_commit_err got %b want 1", key_err); errs++; end
        vecs++; if (load_cnt !== 4'd8) begin $display("FAIL reload_cnt got %0d want 8", load_cnt); errs++; end
        vecs++; if (sig_out !== 4'hA) begin $display("FAIL reload_still_pass got %b want 1010", sig_out); errs++; end
        commit();
        sig_in = 4'b0110;
        #1;
        vecs++; if (sig_out !== 4'b1001) begin $display("FAIL reload_inv got %b want 1001", sig_out); errs++; end
        vecs++; if (key_err !== 1'b0) begin $display("FAIL reload_commit_err got %b want 0", key_err); errs++; end
    endtask

    task automatic test_overshift();
        for (int i = 0; i < 9; i++) shift_bit(1'b1);
        vecs++; if (load_cnt !== 4'd9) begin $display("FAIL over_cnt got %0d want 9", load_cnt); errs++; end
        shift_bit(1'b1);
        vecs++; if (load_cnt !== 4'd9) begin $display("FAIL over_sat got %0d want 9", load_cnt); errs++; end
        commit();
        vecs++; if (key_err !== 1'b1) begin $display("FAIL over_err got %b want 1", key_err); errs++; end
        vecs++; if (sig_out !== 4'b1001) begin $display("FAIL over_keep got %b want 1001", sig_out); errs++; end
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        vecs++; if (load_cnt !== 4'd0) begin $display("FAIL clear_cnt got %0d want 0", load_cnt); errs++; end
        vecs++; if (sig_out !== 4'b0000) begin $display("FAIL clear_sig_out got %b want 0000", sig_out); errs++; end
        vecs++; if (key_ready !== 1'b0) begin $display("FAIL clear_ready got %b want 0", key_ready); errs++; end
    endtask

    task automatic test_reset_mid_shift();
        shift_byte(8'h00);
        commit();
        sig_in = 4'b1111;
        tick();
        vecs++; if (sig_out_r !== 4'b1111) begin $display("FAIL mid_pre_reg got %b want 1111", sig_out_r); errs++; end
        vecs++; if (sig_out !== 4'b1111) begin $display("FAIL mid_pre_comb got %b want 1111", sig_out); errs++; end
        shift_bit(1'b0);
        shift_bit(1'b1);
        key_shift = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key_shift = 1'b0;
        vecs++; if (sig_out !== 4'b0000) begin $display("FAIL mid_rst_comb got %b want 0000", sig_out); errs++; end
        vecs++; if (sig_out_r !== 4'b0000) begin $display("FAIL mid_rst_reg got %b want 0000", sig_out_r); errs++; end
        vecs++; if (load_cnt_r !== 4'd0) begin $display("FAIL mid_rst_cnt got %0d want 0", load_cnt_r); errs++; end
        commit();
        vecs++; if (key_err !== 1'b1) begin $display("FAIL locked_commit_err got %b want 1", key_err); errs++; end
        vecs++; if (key_err_r !== 1'b1) begin $display("FAIL locked_commit_err_r got %b want 1", key_err_r); errs++; end
        vecs++; if (key_ready !== 1'b0) begin $display("FAIL locked_commit_ready got %b want 0", key_ready); errs++; end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_short_load();
        test_reload_traffic();
        test_overshift();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
